// File: rtl/scsi_target_link.sv
// Target-side SCSI bus engine.
// Answers selection of SCSI ID `ID`, then runs COMMAND, optional DATA IN / DATA OUT,
// STATUS and MESSAGE IN phases using the target side of the REQ/ACK byte handshake.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   scsi_rst, sel, atn, ack    initiator bus controls (atn unused)
//   din / dout                 initiator / target data bus
//   bsy, msg, cd, io, req      target bus controls
//   cmd_valid, cdb, cdb_len    completed CDB toward the command processor
//   resp_*                     processor response (accepted only while waiting)
//   tx_* / rx_*                data-in source stream / data-out sink pulses
module scsi_target_link #(
  parameter logic [2:0] ID = 3'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scsi_rst,
  input  logic        sel,
  input  logic        atn,
  input  logic        ack,
  input  logic [7:0]  din,
  output logic        bsy,
  output logic        msg,
  output logic        cd,
  output logic        io,
  output logic        req,
  output logic [7:0]  dout,
  output logic        cmd_valid,
  output logic [95:0] cdb,
  output logic [3:0]  cdb_len,
  input  logic        resp_valid,
  input  logic [1:0]  resp_dir,
  input  logic [23:0] resp_len,
  input  logic [7:0]  resp_status,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid
);

  typedef enum logic [2:0] {
    StIdle, StSelected, StCmd, StCmdWait, StDin, StDout, StStatus, StMsgin
  } state_e;

  state_e        state_q, state_d;
  logic          bsy_q, bsy_d, msg_q, msg_d, cd_q, cd_d, io_q, io_d, req_q, req_d;
  logic [7:0]    dout_q, dout_d, status_q, status_d, rx_data_q, rx_data_d;
  logic [95:0]   cdb_q, cdb_d;
  logic [3:0]    cdb_len_q, cdb_len_d, idx_q, idx_d, exp_len_q, exp_len_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          have_q, have_d;   // send byte sitting stable on dout
  logic          done_q, done_d;   // last byte of the phase completed, req already low
  logic          cmd_valid_q, cmd_valid_d, tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;

  logic          xfer, send_ph, raise, to_status;
  logic [3:0]    grp_len, cur_len;
  logic [7:0]    st_byte;
  logic          unused_atn;

  assign unused_atn = atn;

  always_comb begin
    unique case (din[7:5])
      3'd1, 3'd2: grp_len = 4'd10;
      3'd5:       grp_len = 4'd12;
      default:    grp_len = 4'd6;
    endcase
  end

  assign cur_len = (idx_q == 4'd0) ? grp_len : exp_len_q;
  assign xfer    = req_q && ack;
  assign send_ph = (state_q == StDin) || (state_q == StStatus) || (state_q == StMsgin);
  // A new req waits for ack low and, when sending, for dout settled one cycle.
  assign raise   = !req_q && !ack && !done_q && (!send_ph || have_q);

  always_comb begin
    state_d     = state_q;
    bsy_d       = bsy_q;
    msg_d       = msg_q;
    cd_d        = cd_q;
    io_d        = io_q;
    req_d       = req_q;
    dout_d      = dout_q;
    status_d    = status_q;
    rx_data_d   = rx_data_q;
    cdb_d       = cdb_q;
    cdb_len_d   = cdb_len_q;
    idx_d       = idx_q;
    exp_len_d   = exp_len_q;
    cnt_d       = cnt_q;
    have_d      = have_q;
    done_d      = done_q;
    cmd_valid_d = 1'b0;
    tx_ready_d  = 1'b0;
    rx_valid_d  = 1'b0;
    to_status   = 1'b0;
    st_byte     = status_q;

    unique case (state_q)
      StIdle: begin
        if (sel && din[ID] && !bsy_q) begin
          state_d = StSelected;
          bsy_d   = 1'b1;
          cdb_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      end
      StSelected: begin
        if (!sel) begin
          state_d = StCmd;
          cd_d    = 1'b1;
        end
      end
      StCmd: begin
        if (xfer) begin
          req_d = 1'b0;
          for (int i = 0; i < 12; i++) begin
            if (idx_q == 4'(i)) cdb_d[i*8 +: 8] = din;
          end
          if (idx_q == 4'd0) exp_len_d = grp_len;
          idx_d = (idx_q == 4'd11) ? 4'd11 : idx_q + 4'd1;
          if (idx_q + 4'd1 == cur_len) done_d = 1'b1;
        end else if (done_q) begin
          cmd_valid_d = 1'b1;
          cdb_len_d   = exp_len_q;
          done_d      = 1'b0;
          state_d     = StCmdWait;
        end else if (raise) begin
          req_d = 1'b1;
        end
      end
      StCmdWait: begin
        if (resp_valid) begin
          status_d = resp_status;
          cnt_d    = resp_len;
          if (resp_dir == 2'd1 && resp_len != '0) begin
            state_d = StDin;
            cd_d    = 1'b0;
            io_d    = 1'b1;
          end else if (resp_dir == 2'd2 && resp_len != '0) begin
            state_d = StDout;
            cd_d    = 1'b0;
            io_d    = 1'b0;
          end else begin
            to_status = 1'b1;
            st_byte   = resp_status;
          end
        end
      end
      StDin: begin
        if (xfer) begin
          req_d  = 1'b0;
          have_d = 1'b0;
          cnt_d  = cnt_q - 24'd1;
          if (cnt_q == 24'd1) done_d = 1'b1;
        end else if (done_q) begin
          to_status = 1'b1;
        end else if (tx_ready_q && tx_valid) begin
          dout_d = tx_data;
          have_d = 1'b1;
        end else if (raise) begin
          req_d = 1'b1;
        end else if (!have_q && !req_q && !ack) begin
          tx_ready_d = 1'b1;
        end
      end
      StDout: begin
        if (xfer) begin
          req_d      = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = din;
          cnt_d      = cnt_q - 24'd1;
          if (cnt_q == 24'd1) done_d = 1'b1;
        end else if (done_q) begin
          to_status = 1'b1;
        end else if (raise) begin
          req_d = 1'b1;
        end
      end
      StStatus: begin
        if (xfer) begin
          req_d  = 1'b0;
          have_d = 1'b0;
          done_d = 1'b1;
        end else if (done_q) begin
          state_d = StMsgin;
          msg_d   = 1'b1;
          dout_d  = 8'h00;  // COMMAND COMPLETE
          have_d  = 1'b1;
          done_d  = 1'b0;
        end else if (raise) begin
          req_d = 1'b1;
        end
      end
      StMsgin: begin
        if (xfer) begin
          // Bus free: bsy and phase lines release together with req.
          state_d = StIdle;
          req_d   = 1'b0;
          bsy_d   = 1'b0;
          msg_d   = 1'b0;
          cd_d    = 1'b0;
          io_d    = 1'b0;
          dout_d  = 8'h00;
          have_d  = 1'b0;
        end else if (raise) begin
          req_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (to_status) begin
      state_d = StStatus;
      msg_d   = 1'b0;
      cd_d    = 1'b1;
      io_d    = 1'b1;
      dout_d  = st_byte;
      have_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || scsi_rst) begin
      state_q     <= StIdle;
      bsy_q       <= 1'b0;
      msg_q       <= 1'b0;
      cd_q        <= 1'b0;
      io_q        <= 1'b0;
      req_q       <= 1'b0;
      dout_q      <= '0;
      status_q    <= '0;
      rx_data_q   <= '0;
      cdb_q       <= '0;
      cdb_len_q   <= '0;
      idx_q       <= '0;
      exp_len_q   <= '0;
      cnt_q       <= '0;
      have_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bsy_q       <= bsy_d;
      msg_q       <= msg_d;
      cd_q        <= cd_d;
      io_q        <= io_d;
      req_q       <= req_d;
      dout_q      <= dout_d;
      status_q    <= status_d;
      rx_data_q   <= rx_data_d;
      cdb_q       <= cdb_d;
      cdb_len_q   <= cdb_len_d;
      idx_q       <= idx_d;
      exp_len_q   <= exp_len_d;
      cnt_q       <= cnt_d;
      have_q      <= have_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bsy       = bsy_q;
  assign msg       = msg_q;
  assign cd        = cd_q;
  assign io        = io_q;
  assign req       = req_q;
  assign dout      = dout_q;
  assign cmd_valid = cmd_valid_q;
  assign cdb       = cdb_q;
  assign cdb_len   = cdb_len_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_scsi_target_link.sv
// Directed bench for scsi_target_link: plays the initiator and the data source,
// checks bus phases, bytes and processor-side strobes against hand-computed values.
module tb_scsi_target_link;

  logic        clk = 1'b0;
  logic        reset, scsi_rst, sel, atn, ack;
  logic [7:0]  din;
  logic        bsy, msg, cd, io, req;
  logic [7:0]  dout;
  logic        cmd_valid;
  logic [95:0] cdb;
  logic [3:0]  cdb_len;
  logic        resp_valid;
  logic [1:0]  resp_dir;
  logic [23:0] resp_len;
  logic [7:0]  resp_status;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  always #5 clk = ~clk;

  scsi_target_link #(.ID(3'd6)) dut (
    .clk(clk), .reset(reset), .scsi_rst(scsi_rst), .sel(sel), .atn(atn), .ack(ack),
    .din(din), .bsy(bsy), .msg(msg), .cd(cd), .io(io), .req(req), .dout(dout),
    .cmd_valid(cmd_valid), .cdb(cdb), .cdb_len(cdb_len), .resp_valid(resp_valid),
    .resp_dir(resp_dir), .resp_len(resp_len), .resp_status(resp_status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cmd_cnt = 0;
  int ph_viol = 0;
  logic [2:0] ph_prev = 3'b000;
  logic       req_prev = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Initiator drives a byte (COMMAND / DATA OUT).
  task automatic send_out(input string tag, input logic [7:0] b, input logic [2:0] ph,
                          input int hold);
    bit ok;
    int stray;
    din = b;
    wait_req(ok);
    check({tag, "_req"}, ok, 1'b1);
    if (!ok) return;
    check({tag, "_ph"}, {msg, cd, io}, ph);
    ack   = 1'b1;
    stray = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (req) stray++;
    end
    ack = 1'b0;
    check({tag, "_reqdrop"}, stray, 0);
  endtask

  // Initiator takes a byte (DATA IN / STATUS / MESSAGE IN).
  task automatic recv_in(input string tag, input logic [2:0] ph, input logic [7:0] want,
                         input int hold);
    bit ok;
    int stray;
    wait_req(ok);
    check({tag, "_req"}, ok, 1'b1);
    if (!ok) return;
    check({tag, "_ph"}, {msg, cd, io}, ph);
    check({tag, "_dat"}, dout, want);
    ack   = 1'b1;
    stray = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (req) stray++;
    end
    ack = 1'b0;
    check({tag, "_reqdrop"}, stray, 0);
  endtask

  task automatic select_me();
    din = 8'h40;
    sel = 1'b1;
    step();
    check("sel_bsy", bsy, 1'b1);
    step();
    check("sel_hold_cd", cd, 1'b0);
    sel = 1'b0;
    din = 8'h00;
    step();
    check("sel_cmd_cd", cd, 1'b1);
  endtask

  task automatic send_cdb(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) send_out("cdb", v[i*8 +: 8], 3'b010, 1);
  endtask

  task automatic respond(input logic [1:0] dir, input logic [23:0] len, input logic [7:0] st);
    resp_dir    = dir;
    resp_len    = len;
    resp_status = st;
    resp_valid  = 1'b1;
    step();
    resp_valid  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {bsy, msg, cd, io, req, tx_ready, rx_valid, cmd_valid}, 8'h00);
    check({tag, "_dout"}, dout, 8'h00);
    check({tag, "_cdb"}, cdb, 96'h0);
    check({tag, "_len"}, cdb_len, 4'd0);
  endtask

  // Data-in source: pop a byte after each accepted handshake.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      bit acc;
      @(negedge clk);
      acc = tx_valid && tx_ready;
      @(posedge clk);
      #2;
      if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (cmd_valid) cmd_cnt++;
    if (rx_valid) rx_got.push_back(rx_data);
    if (bsy && ({msg, cd, io} != ph_prev) && (req || req_prev)) ph_viol++;
    ph_prev  <= {msg, cd, io};
    req_prev <= req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; scsi_rst = 1'b0; sel = 1'b0; atn = 1'b0; ack = 1'b0; din = 8'h00;
    resp_valid = 1'b0; resp_dir = 2'd0; resp_len = '0; resp_status = 8'h00;
    repeat (2) step();
    check_idle("rst");
    reset = 1'b0;

    // Wrong ID must not select.
    sel = 1'b1;
    din = 8'h20;
    repeat (3) step();
    check("sel_other_id", bsy, 1'b0);
    sel = 1'b0;
    din = 8'h00;
    step();

    // READ(6) with a 4-byte data-in phase.
    select_me();
    send_cdb(96'h000201000008, 6);
    repeat (2) step();
    check("r6_cmdv", cmd_cnt, 1);
    check("r6_len", cdb_len, 4'd6);
    check("r6_cdb", cdb, 96'h000201000008);
    check("r6_wait_req", req, 1'b0);
    tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    respond(2'd1, 24'd4, 8'h00);
    for (int i = 0; i < 4; i++) recv_in("din", 3'b001, 8'hA1 + 8'(i), 1);
    recv_in("r6_st", 3'b011, 8'h00, 1);
    recv_in("r6_mi", 3'b111, 8'h00, 1);
    check("r6_busfree", {bsy, msg, cd, io, dout}, 12'h000);

    // WRITE(10) with 3 data-out bytes, ack as 1-cycle pulses.
    select_me();
    send_cdb(96'h0003000010000000002A, 10);
    repeat (2) step();
    check("w10_cmdv", cmd_cnt, 2);
    check("w10_len", cdb_len, 4'd10);
    check("w10_cdb", cdb, 96'h0003000010000000002A);
    respond(2'd2, 24'd3, 8'h02);
    send_out("dout1", 8'h11, 3'b000, 1);
    send_out("dout2", 8'h22, 3'b000, 1);
    send_out("dout3", 8'h33, 3'b000, 1);
    recv_in("w10_st", 3'b011, 8'h02, 1);
    recv_in("w10_mi", 3'b111, 8'h00, 1);
    check("w10_rxn", rx_got.size(), 3);
    if (rx_got.size() == 3) begin
      check("w10_rx0", rx_got[0], 8'h11);
      check("w10_rx1", rx_got[1], 8'h22);
      check("w10_rx2", rx_got[2], 8'h33);
    end

    // Zero-length data-in skips to STATUS; ack held 5 cycles consumes one byte.
    select_me();
    send_cdb(96'h000201000008, 6);
    repeat (2) step();
    respond(2'd1, 24'd0, 8'h00);
    recv_in("z_st", 3'b011, 8'h00, 5);
    recv_in("z_mi", 3'b111, 8'h00, 1);
    check("z_cmdv", cmd_cnt, 3);
    check("z_rxn", rx_got.size(), 3);

    // scsi_rst after the second data-in byte.
    select_me();
    send_cdb(96'h000201000008, 6);
    repeat (2) step();
    tx_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    respond(2'd1, 24'd4, 8'h00);
    recv_in("ab_d1", 3'b001, 8'hB1, 1);
    recv_in("ab_d2", 3'b001, 8'hB2, 1);
    scsi_rst = 1'b1;
    step();
    scsi_rst = 1'b0;
    check_idle("ab_rst");
    tx_q.delete();
    repeat (2) step();
    select_me();
    send_cdb(96'h000105000008, 6);
    repeat (2) step();
    check("ab_cmdv", cmd_cnt, 5);
    check("ab_cdb", cdb, 96'h000105000008);
    respond(2'd0, 24'd9, 8'h00);
    recv_in("ab_st", 3'b011, 8'h00, 1);
    recv_in("ab_mi", 3'b111, 8'h00, 1);

    // reset in the middle of COMMAND, then a 12-byte CDB.
    select_me();
    send_cdb(96'h000201000008, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rc_rst");
    select_me();
    send_cdb(96'h0000040000001000000000A8, 12);
    repeat (2) step();
    check("rc_cmdv", cmd_cnt, 6);
    check("rc_len", cdb_len, 4'd12);
    check("rc_cdb", cdb, 96'h0000040000001000000000A8);
    respond(2'd3, 24'd5, 8'h22);
    recv_in("rc_st", 3'b011, 8'h22, 1);
    recv_in("rc_mi", 3'b111, 8'h00, 1);
    check("rc_busfree", bsy, 1'b0);

    check("phase_vs_req", ph_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scsi_target_link.md
Name: scsi_target_link

Overview:
- Target-side SCSI bus engine: the responder for the initiator handshake driven by the 5380 host controller.
- Detects selection of its ID, drives BSY/MSG/C/D/I/O/REQ, and sequences COMMAND, DATA IN/OUT, STATUS and MESSAGE IN phases with the REQ/ACK byte handshake.
- Delivers the CDB to a command processor and exchanges data bytes over valid/ready streams.
- Sits between the initiator bus signals and a disk command/sector-buffer layer.

Parameters:
ID, 3'd6, SCSI ID this target answers to (selection bit din[ID])

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
scsi_rst  in  1  SCSI bus RST from initiator
sel  in  1  SCSI SEL
atn  in  1  SCSI ATN (ignored; no MESSAGE OUT support)
ack  in  1  SCSI ACK (may be a 1-cycle pulse or a level)
din  in  8  initiator data bus
bsy  out  1  SCSI BSY
msg  out  1  SCSI MSG
cd  out  1  SCSI C/D
io  out  1  SCSI I/O
req  out  1  SCSI REQ
dout  out  8  target data bus
cmd_valid  out  1  1-cycle pulse: CDB complete
cdb  out  96  CDB bytes, byte0 in [7:0], byte n in [8n+7:8n]
cdb_len  out  4  number of CDB bytes received (6/10/12)
resp_valid  in  1  processor response strobe, accepted only in CMD_WAIT
resp_dir  in  2  0 none, 1 data in (to initiator), 2 data out, 3 treated as 0
resp_len  in  24  byte count of data phase
resp_status  in  8  status byte for STATUS phase
tx_data  in  8  data-in byte
tx_valid  in  1  data-in byte available
tx_ready  out  1  engine wants a data-in byte
rx_data  out  8  data-out byte
rx_valid  out  1  1-cycle pulse: rx_data valid

Behaviour:
- Reset (reset=1 at a clk edge), or scsi_rst=1 sampled at a clk edge, forces the following on the next cycle:
  - state IDLE;
  - bsy, msg, cd, io, req, cmd_valid, tx_ready, rx_valid all 0;
  - dout 0, cdb 0, cdb_len 0, byte counters 0.
- scsi_rst aborts any phase.
- States and transitions:
  - IDLE, all bus outputs 0: if sel=1 & din[ID]=1 & bsy=0, go to SELECTED; bsy=1 in the next cycle.
  - SELECTED, bsy=1: wait for sel=0, then go to CMD.
  - CMD, cd=1 io=0 msg=0:
    - Receive bytes via the handshake. Byte0 sets the length: group din[7:5]=0 -> 6, 1 or 2 -> 10, 5 -> 12, other -> 6.
    - After the last byte: cdb_len set, cmd_valid pulses 1 cycle, go to CMD_WAIT.
  - CMD_WAIT, bsy=1, req=0: on resp_valid latch dir/len/status.
    - dir=1 & len!=0 -> DIN.
    - dir=2 & len!=0 -> DOUT.
    - else -> STATUS.
  - DIN, io=1 cd=0 msg=0:
    - With req=0 and ack=0, tx_ready=1. On tx_valid&tx_ready, latch tx_data into dout, drop tx_ready, assert req next cycle.
    - After len bytes -> STATUS.
  - DOUT, io=0 cd=0 msg=0: per byte, latch din on ack and pulse rx_valid with rx_data=din. After len bytes -> STATUS.
  - STATUS, cd=1 io=1: send resp_status, then -> MSGIN.
  - MSGIN, msg=1 cd=1 io=1: send 8'h00 (COMMAND COMPLETE), then -> IDLE; bsy, phase lines and dout go to 0 the cycle after the final ack.
- REQ/ACK handshake, target side, per byte:
  - assert req only with ack=0 and dout/phase stable, at least 1 cycle before req rises;
  - while req=1, the first cycle with ack=1 completes the byte (data-out/command: din sampled that cycle) and req=0 next cycle;
  - the next req is not raised until ack has been observed 0 (a 1-cycle ack pulse satisfies this the following cycle).
- Phase lines change only while req=0.
- Counters:
  - 24-bit down-counter loaded from resp_len, decremented per completed byte; phase exit at count reaching 0.
  - CDB index 4-bit, saturates at 11.
- Ignored inputs:
  - sel asserted while not IDLE is ignored.
  - ack with req=0 is ignored.
  - resp_valid outside CMD_WAIT is ignored.
  - atn is ignored.
- tx_valid without tx_ready: no effect; data held by source.

Test Plan:
- Selection mismatch: ID=6, sel=1, din=8'h20 -> bsy stays 0. din=8'h40 -> bsy=1 next cycle, CMD entered (cd=1) only after sel drops.
- READ(6) 08 00 00 01 02 00 over 6 REQ/ACK pairs -> cmd_valid 1 cycle, cdb_len=6, cdb[47:0]=48'h00020100_0008.
- Data-in flow:
  - Response: resp_dir=1, resp_len=4, resp_status=0, bytes A1 A2 A3 A4.
  - Required: 4 REQs with io=1, dout=A1..A4; then STATUS (cd=io=1, dout=00); then MSGIN (msg=1, dout=00); then bsy=0.
- WRITE(10): opcode 2A (10 CDB bytes, cdb_len=10). Response resp_dir=2, resp_len=3; initiator drives 11 22 33 with 1-cycle ack pulses -> 3 rx_valid pulses with rx_data 11, 22, 33, then STATUS with resp_status=02 on dout.
- Zero-length and handshake rules:
  - resp_dir=1, resp_len=0 -> skip to STATUS.
  - ack held high 5 cycles -> single byte consumed, no new req until ack=0.
- Aborts:
  - scsi_rst pulse mid DIN after byte 2 -> next cycle all outputs 0, state IDLE; a fresh selection then works.
  - reset mid CMD behaves the same.
